// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame scheduler: FSM states,
// frame marker/type bytes, host command codes and payload lengths.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        TYPE,
        PAYLOAD,
        CSUM
    } state_t;

    localparam logic [7:0] HDR_BYTE = 8'hA5;
    localparam logic [7:0] TYPE_HT  = 8'h01;
    localparam logic [7:0] TYPE_DBG = 8'h02;

    localparam logic [7:0] CMD_EN   = 8'h01;
    localparam logic [7:0] CMD_DIS  = 8'h00;

    // payload bytes per frame; a frame adds header, type and checksum
    localparam logic [2:0] LEN_HT   = 3'd6;
    localparam logic [2:0] LEN_DBG  = 3'd3;

endpackage

// File: rtl/uart_tx_frame_sched_if.sv
// Word producers, host RX strobe, byte transmitter and status, bundled as one port.
// master = environment side (producers/host/transmitter), slave = scheduler side.
interface uart_tx_frame_sched_if;

    logic [47:0] i_ht_data;
    logic        i_ht_valid;
    logic        o_ht_ready;
    logic [23:0] i_dbg_data;
    logic        i_dbg_valid;
    logic        o_dbg_ready;
    logic [7:0]  i_rx_data;
    logic        i_rx_done;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic        o_stream_en;
    logic [15:0] o_frame_cnt;
    logic        o_busy;

    modport master (
        output i_ht_data, i_ht_valid, i_dbg_data, i_dbg_valid,
               i_rx_data, i_rx_done, i_tx_ready,
        input  o_ht_ready, o_dbg_ready, o_tx_data, o_tx_valid,
               o_stream_en, o_frame_cnt, o_busy
    );

    modport slave (
        input  i_ht_data, i_ht_valid, i_dbg_data, i_dbg_valid,
               i_rx_data, i_rx_done, i_tx_ready,
        output o_ht_ready, o_dbg_ready, o_tx_data, o_tx_valid,
               o_stream_en, o_frame_cnt, o_busy
    );

endinterface

// File: rtl/uart_rr_arb2.sv
// Two-requester round-robin arbiter; the last-granted side only moves on an
// accepted word, so a stalled grant does not flip priority.
module uart_rr_arb2 (
    input  logic i_clk_sys,
    input  logic i_rst,
    input  logic req_ht,
    input  logic req_dbg,
    input  logic accept,
    output logic grant_ht,
    output logic grant_dbg
);

    logic last_grant_dbg;

    always_comb begin
        grant_ht  = req_ht  & (~req_dbg | last_grant_dbg);
        grant_dbg = req_dbg & (~req_ht  | ~last_grant_dbg);
    end

    // reset to DBG so the hidden-state stream wins the first tie
    always_ff @(posedge i_clk_sys or posedge i_rst) begin
        if (i_rst)       last_grant_dbg <= 1'b1;
        else if (accept) last_grant_dbg <= grant_dbg;
    end

endmodule

// File: rtl/uart_tx_frame_sched.sv
// Frame scheduler: arbitrates HT/DBG words, emits A5/type/payload/checksum
// bytes to the UART transmitter, paced by i_tx_ready with a post-issue holdoff.
module uart_tx_frame_sched
    import uart_frame_pkg::*;
#(
    parameter int HOLDOFF = 2
) (
    input  logic                  i_clk_sys,
    input  logic                  i_rst,
    uart_tx_frame_sched_if.slave  bus
);

    localparam logic [3:0] HOLD_LD = 4'(HOLDOFF);

    state_t      state, state_nxt;
    logic        stream_en;
    logic [47:0] shift_q;
    logic [7:0]  type_q;
    logic [7:0]  csum_q;
    logic [7:0]  tx_data_q;
    logic [7:0]  cur_byte;
    logic [2:0]  cnt_q;
    logic [3:0]  hold_q;
    logic [15:0] frame_cnt;
    logic        grant_ht, grant_dbg;
    logic        accept, issue;

    uart_rr_arb2 u_arb (
        .i_clk_sys (i_clk_sys),
        .i_rst     (i_rst),
        .req_ht    (bus.i_ht_valid),
        .req_dbg   (bus.i_dbg_valid),
        .accept    (accept),
        .grant_ht  (grant_ht),
        .grant_dbg (grant_dbg)
    );

    assign bus.o_ht_ready  = (state == IDLE) & stream_en & grant_ht;
    assign bus.o_dbg_ready = (state == IDLE) & stream_en & grant_dbg;
    assign accept = (bus.o_ht_ready & bus.i_ht_valid) | (bus.o_dbg_ready & bus.i_dbg_valid);
    assign issue  = (state != IDLE) & bus.i_tx_ready & (hold_q == 4'd0);

    always_ff @(posedge i_clk_sys or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)                    state_nxt = HDR;
            HDR:     if (issue)                     state_nxt = TYPE;
            TYPE:    if (issue)                     state_nxt = PAYLOAD;
            PAYLOAD: if (issue && cnt_q == 3'd1)    state_nxt = CSUM;
            CSUM:    if (issue)                     state_nxt = IDLE;
            default:                                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        case (state)
            HDR:     cur_byte = HDR_BYTE;
            TYPE:    cur_byte = type_q;
            PAYLOAD: cur_byte = shift_q[47:40];
            CSUM:    cur_byte = csum_q;
            default: cur_byte = tx_data_q;
        endcase
        bus.o_tx_valid = issue;
        bus.o_tx_data  = issue ? cur_byte : tx_data_q;
        bus.o_busy     = (state != IDLE);
    end

    // datapath: word latch on accept, shift/checksum/count on payload issues
    always_ff @(posedge i_clk_sys or posedge i_rst) begin
        if (i_rst) begin
            shift_q   <= '0;
            type_q    <= '0;
            csum_q    <= '0;
            cnt_q     <= '0;
            tx_data_q <= '0;
            hold_q    <= '0;
        end else begin
            if (accept) begin
                shift_q <= grant_ht ? bus.i_ht_data : {bus.i_dbg_data, 24'h0};
                type_q  <= grant_ht ? TYPE_HT : TYPE_DBG;
                csum_q  <= grant_ht ? TYPE_HT : TYPE_DBG;
                cnt_q   <= grant_ht ? LEN_HT  : LEN_DBG;
            end else if (issue && state == PAYLOAD) begin
                shift_q <= {shift_q[39:0], 8'h00};
                csum_q  <= csum_q ^ shift_q[47:40];
                cnt_q   <= cnt_q - 3'd1;
            end
            if (issue)               tx_data_q <= cur_byte;
            if (issue)               hold_q    <= HOLD_LD;
            else if (hold_q != 4'd0) hold_q    <= hold_q - 4'd1;
        end
    end

    always_ff @(posedge i_clk_sys or posedge i_rst) begin
        if (i_rst) begin
            stream_en <= 1'b0;
        end else if (bus.i_rx_done) begin
            if (bus.i_rx_data == CMD_EN)       stream_en <= 1'b1;
            else if (bus.i_rx_data == CMD_DIS) stream_en <= 1'b0;
        end
    end

    always_ff @(posedge i_clk_sys or posedge i_rst) begin
        if (i_rst)                      frame_cnt <= '0;
        else if (issue && state == CSUM) frame_cnt <= frame_cnt + 16'd1;
    end

    assign bus.o_stream_en = stream_en;
    assign bus.o_frame_cnt = frame_cnt;

endmodule
